// File: rtl/mode_counter_pkg.sv
// Shared constants for the mode counter block.
//   MODE_WRAP : on a bound event, wrap to the opposite bound
//   MODE_SAT  : on a bound event, stick at the bound that was crossed
package mode_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/mode_counter_next.sv
// Combinational next-count and bound-event logic for mode_counter.
// Ports:
//   cur        current count
//   limit      active upper bound
//   en         advance enable (already qualified by clear/load/clamp)
//   countdown  1 = subtract step, 0 = add step
//   step       unsigned magnitude; 0 holds
//   nxt        next count (equals cur when en is low)
//   evt_up     increment would pass limit
//   evt_dn     decrement would pass 0
module mode_counter_next
    import mode_counter_pkg::*;
#(
    parameter int   WIDTH  = 8,
    parameter int   STEP_W = 4,
    parameter logic MODE   = MODE_WRAP
) (
    input  logic [WIDTH-1:0]  cur,
    input  logic [WIDTH-1:0]  limit,
    input  logic              en,
    input  logic              countdown,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  nxt,
    output logic              evt_up,
    output logic              evt_dn
);

    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // One extra bit so out + step can exceed an all-ones limit.
        step_ext = (WIDTH+1)'(step);
        sum      = {1'b0, cur} + step_ext;
        diff     = cur - step_ext[WIDTH-1:0];
        nxt      = cur;
        evt_up   = 1'b0;
        evt_dn   = 1'b0;
        if (en && !countdown) begin
            if (sum > {1'b0, limit}) begin
                evt_up = 1'b1;
                nxt    = (MODE == MODE_SAT) ? limit : '0;
            end else begin
                nxt = sum[WIDTH-1:0];
            end
        end else if (en && countdown) begin
            if (step_ext > {1'b0, cur}) begin
                evt_dn = 1'b1;
                nxt    = (MODE == MODE_SAT) ? '0 : limit;
            end else begin
                nxt = diff;
            end
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with programmable upper bound, wrap or saturate behaviour,
// terminal-count pulse and sticky overflow/underflow flags.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   clear, load         sync clear / load (load_val clamped to limit)
//   limit_we, limit_val limit register write; lowering below count clamps it
//   en, countdown, step count enable, direction, step magnitude
//   flag_clr            clears ovf/unf (a same-edge set wins)
//   out                 registered count
//   tc                  registered pulse the cycle after a bound event
//   ovf, unf            sticky bound flags
//   at_limit            combinational out == limit
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              limit_we,
    input  logic [WIDTH-1:0]  limit_val,
    input  logic              en,
    input  logic              countdown,
    input  logic [STEP_W-1:0] step,
    input  logic              flag_clr,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              at_limit
);

    localparam logic MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] step_nxt;
    logic             evt_up, evt_dn;
    logic             clamp;
    logic             count_en;

    // A limit write below the current count forces the count down and
    // suppresses counting that cycle, so it can never raise an event.
    assign clamp    = limit_we && (limit_val < count_q);
    assign count_en = en && !clear && !load && !clamp;

    mode_counter_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .MODE   (MODE)
    ) u_next (
        .cur       (count_q),
        .limit     (limit_q),
        .en        (count_en),
        .countdown (countdown),
        .step      (step),
        .nxt       (step_nxt),
        .evt_up    (evt_up),
        .evt_dn    (evt_dn)
    );

    always_comb begin
        count_d = step_nxt;
        limit_d = limit_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > limit_q) ? limit_q : load_val;
        end else if (clamp) begin
            count_d = limit_val;
        end
        if (limit_we) begin
            limit_d = limit_val;
        end
        tc_d  = evt_up | evt_dn;
        ovf_d = evt_up | (ovf_q & ~flag_clr);
        unf_d = evt_dn | (unf_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            limit_q <= '1;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign out      = count_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign at_limit = (count_q == limit_q);

endmodule

// File: tb/tb_mode_counter.sv
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear, load, limit_we, en, countdown, flag_clr;
    logic [7:0] load_val, limit_val;
    logic [3:0] step;

    logic [7:0] out_w, out_s;
    logic       tc_w, ovf_w, unf_w, atl_w;
    logic       tc_s, ovf_s, unf_s, atl_s;

    int errors = 0;
    int checks = 0;

    // Reference state, index 0 = wrap instance, 1 = saturate instance.
    int m_out[2];
    int m_lim[2];
    int m_tc[2];
    int m_ovf[2];
    int m_unf[2];

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(8), .STEP_W(4), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_val(load_val), .limit_we(limit_we), .limit_val(limit_val),
        .en(en), .countdown(countdown), .step(step), .flag_clr(flag_clr),
        .out(out_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w), .at_limit(atl_w)
    );

    mode_counter #(.WIDTH(8), .STEP_W(4), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_val(load_val), .limit_we(limit_we), .limit_val(limit_val),
        .en(en), .countdown(countdown), .step(step), .flag_clr(flag_clr),
        .out(out_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s), .at_limit(atl_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_out[s] = 0; m_lim[s] = 255; m_tc[s] = 0; m_ovf[s] = 0; m_unf[s] = 0;
        end
    endtask

    // Behaviour of one clock edge from the rule list, in plain integers.
    task automatic model_step(input int s);
        int o, l, ev_up, ev_dn, st;
        o = m_out[s]; l = m_lim[s]; ev_up = 0; ev_dn = 0; st = int'(step);
        if (clear) o = 0;
        else if (load) o = (int'(load_val) > l) ? l : int'(load_val);
        else if (limit_we && int'(limit_val) < o) o = int'(limit_val);
        else if (en && st != 0) begin
            if (!countdown) begin
                if (o + st > l) begin ev_up = 1; o = (s == 1) ? l : 0; end
                else o = o + st;
            end else begin
                if (st > o) begin ev_dn = 1; o = (s == 1) ? 0 : l; end
                else o = o - st;
            end
        end
        if (limit_we) l = int'(limit_val);
        m_out[s] = o;
        m_lim[s] = l;
        m_tc[s]  = ev_up | ev_dn;
        m_ovf[s] = ev_up ? 1 : (flag_clr ? 0 : m_ovf[s]);
        m_unf[s] = ev_dn ? 1 : (flag_clr ? 0 : m_unf[s]);
    endtask

    task automatic check_all();
        chk("w_out", out_w, m_out[0]);
        chk("w_tc",  tc_w,  m_tc[0]);
        chk("w_ovf", ovf_w, m_ovf[0]);
        chk("w_unf", unf_w, m_unf[0]);
        chk("w_atl", atl_w, (m_out[0] == m_lim[0]) ? 1 : 0);
        chk("s_out", out_s, m_out[1]);
        chk("s_tc",  tc_s,  m_tc[1]);
        chk("s_ovf", ovf_s, m_ovf[1]);
        chk("s_unf", unf_s, m_unf[1]);
        chk("s_atl", atl_s, (m_out[1] == m_lim[1]) ? 1 : 0);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cyc();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle();
        clear = 0; load = 0; limit_we = 0; en = 0; countdown = 0; flag_clr = 0;
        load_val = '0; limit_val = '0; step = '0;
    endtask

    initial begin
        int prev_w;
        bit wrap_seen;
        reset_n = 1'b1;
        idle();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out", out_w, 0);
        chk("rst_tc",  tc_w,  0);
        chk("rst_ovf", ovf_s, 0);
        chk("rst_unf", unf_s, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Count up by 1 through the full 8-bit range in wrap mode.
        en = 1; step = 4'd1;
        prev_w = 0; wrap_seen = 0;
        for (int i = 0; i < 260; i++) begin
            cyc();
            if (prev_w == 255 && out_w == 8'd0) begin
                chk("wrap_tc", tc_w, 1);
                wrap_seen = 1;
            end
            prev_w = int'(out_w);
        end
        chk("wrap_seen", wrap_seen, 1);
        chk("wrap_end",  out_w, 4);
        chk("wrap_ovf",  ovf_w, 1);

        // Saturate at limit 9, step 4.
        idle(); clear = 1; flag_clr = 1; cyc();
        idle(); limit_we = 1; limit_val = 8'd9; cyc();
        idle(); en = 1; step = 4'd4;
        cyc(); chk("sat_o1", out_s, 4); chk("sat_t1", tc_s, 0);
        cyc(); chk("sat_o2", out_s, 8); chk("sat_t2", tc_s, 0);
        cyc(); chk("sat_o3", out_s, 9); chk("sat_t3", tc_s, 1);
        idle(); cyc(); chk("sat_o4", out_s, 9); chk("sat_t4", tc_s, 0);
        chk("sat_ovf", ovf_s, 1);

        // Wrap countdown from 5 with limit 9, step 3.
        idle(); flag_clr = 1; cyc();
        idle(); load = 1; load_val = 8'd5; cyc(); chk("dn_o0", out_w, 5);
        idle(); en = 1; countdown = 1; step = 4'd3;
        cyc(); chk("dn_o1", out_w, 2); chk("dn_unf0", unf_w, 0);
        cyc(); chk("dn_o2", out_w, 9); chk("dn_unf1", unf_w, 1); chk("dn_tc", tc_w, 1);

        // Clear beats load and en; load clamps to limit.
        idle(); clear = 1; load = 1; load_val = 8'd77; en = 1; step = 4'd5; cyc();
        chk("prio_out", out_w, 0);
        idle(); limit_we = 1; limit_val = 8'd100; cyc();
        idle(); load = 1; load_val = 8'd200; cyc();
        chk("ldclamp", out_w, 100);

        // Lowering the limit below the count clamps without events.
        idle(); limit_we = 1; limit_val = 8'd255; cyc();
        idle(); load = 1; load_val = 8'd50; cyc();
        idle(); limit_we = 1; limit_val = 8'd20; cyc();
        chk("lclamp_out", out_w, 20); chk("lclamp_tc", tc_w, 0);
        chk("lclamp_ovf", ovf_w, m_ovf[0]);
        idle(); en = 1; step = 4'd1; flag_clr = 1; cyc();
        chk("setwin_ovf", ovf_w, 1); chk("setwin_tc", tc_w, 1);
        idle(); flag_clr = 1; cyc();
        chk("fclr_ovf", ovf_w, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            idle();
            r = $urandom_range(0, 99);
            if (r < 3) clear = 1;
            else if (r < 8) begin load = 1; load_val = 8'($urandom); end
            else if (r < 12) begin limit_we = 1; limit_val = 8'($urandom_range(3, 255)); end
            else begin
                en = ($urandom_range(0, 9) < 8);
                countdown = 1'($urandom);
                step = 4'($urandom);
            end
            flag_clr = ($urandom_range(0, 19) == 0);
            cyc();
        end

        // Asynchronous reset in the middle of counting.
        idle(); limit_we = 1; limit_val = 8'd200; cyc();
        idle(); en = 1; step = 4'd7;
        for (int i = 0; i < 40; i++) cyc();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_w_out", out_w, 0); chk("arst_w_tc", tc_w, 0);
        chk("arst_w_ovf", ovf_w, 0); chk("arst_w_unf", unf_w, 0);
        chk("arst_s_out", out_s, 0); chk("arst_s_ovf", ovf_s, 0);
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        load = 1; load_val = 8'd255; cyc();
        chk("arst_lim_out", out_w, 255); chk("arst_lim_atl", atl_w, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
